// File: rtl/seq_game_pkg.sv
// Shared definitions for the memory-game display path: digit width, FSM state
// encoding, blank segment pattern and the hex-to-seven-segment table.
// Combinational constants only; no latency or flow control involved.
package seq_game_pkg;

    localparam int DIGIT_W = 4;

    // Segment order is {g,f,e,d,c,b,a}, active-low; all ones turns every segment off.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Raw encodings kept as plain constants so older code that compares
    // against bit patterns keeps working alongside the typed enum.
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHOW   = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = S_IDLE,
        SHOW   = S_SHOW,
        GAP    = S_GAP,
        FINISH = S_FINISH
    } state_e;

    // Index 15 is leftmost: F, E, d, C, b, A, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_to_seg(input logic [DIGIT_W-1:0] hex);
        return SEG_TABLE[hex];
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Hex digit to seven-segment decoder, active-low {g,f,e,d,c,b,a}.
// Latency: purely combinational; the caller registers the result.
// Backpressure: none, output follows input continuously.
// Ports: hex_i - 4-bit digit value; seg_o - segment drive pattern.
module hex_to_seg7
    import seq_game_pkg::*;
(
    input  logic [DIGIT_W-1:0] hex_i,
    output logic [6:0]         seg_o
);

    assign seg_o = hex_to_seg(hex_i);

endmodule

// File: rtl/seq_digit_player.sv
// Plays a captured sequence of hex digits MSD-first on one seven-segment digit,
// with blank gaps between digits and a one-cycle done pulse at the end.
// Latency: first digit lit the cycle after the start edge; all outputs registered.
// Backpressure: none; starts arriving while busy or finishing are dropped, abort cancels.
// Ports: clk/rst (sync, active-low); display & new_seq form the start strobe;
//        seq is the sequence (digit 0 in the top nibble); abort cancels playback;
//        digit_out/digit_idx/digit_valid/seg describe the lit digit; busy, done status.
module seq_digit_player
    import seq_game_pkg::*;
#(
    parameter int DIGITS      = 5,
    parameter int SHOW_CYCLES = 50000000,
    parameter int GAP_CYCLES  = 12500000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      display,
    input  logic                      new_seq,
    input  logic [DIGIT_W*DIGITS-1:0] seq,
    input  logic                      abort,
    output logic [DIGIT_W-1:0]        digit_out,
    output logic [2:0]                digit_idx,
    output logic                      digit_valid,
    output logic [6:0]                seg,
    output logic                      busy,
    output logic                      done
);

    localparam int MAX_CYC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DIGITS - 1);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DIGIT_W*DIGITS-1:0] seq_q, seq_d;
    logic [2:0]                idx_q, idx_d;

    logic [DIGIT_W-1:0]        digit_out_q, digit_out_d;
    logic                      digit_valid_q, digit_valid_d;
    logic [6:0]                seg_q, seg_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic                      start;
    logic [DIGIT_W-1:0]        digit_nxt;
    logic [6:0]                seg_nxt;

    assign start = display & new_seq;

    // Next-state logic. The cycle counter restarts at 0 on every state entry,
    // so it never needs to count past the longer of the two dwell times.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        seq_d   = seq_q;
        idx_d   = idx_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Abort beats a simultaneous start.
                if (start && !abort) begin
                    state_d = SHOW;
                    seq_d   = seq;
                    idx_d   = '0;
                end
            end
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d   = '0;
                    state_d = (idx_q == IDX_LAST) ? FINISH : GAP;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    state_d = SHOW;
                end
            end
            FINISH: begin
                // Abort is not looked at here, so done always pulses once reached.
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Cancelling playback drops everything back to the reset picture.
        if (abort && (state_q == SHOW || state_q == GAP)) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            seq_d   = '0;
        end
    end

    // Output values are derived from the next state so that the registered
    // outputs line up with the state they describe.
    always_comb begin
        digit_nxt = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == 3'(i)) begin
                digit_nxt = seq_d[DIGIT_W*(DIGITS-1-i) +: DIGIT_W];
            end
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .hex_i (digit_nxt),
        .seg_o (seg_nxt)
    );

    always_comb begin
        digit_valid_d = (state_d == SHOW);
        digit_out_d   = digit_valid_d ? digit_nxt : '0;
        seg_d         = digit_valid_d ? seg_nxt : SEG_BLANK;
        busy_d        = (state_d == SHOW) || (state_d == GAP);
        done_d        = (state_d == FINISH);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            seq_q         <= '0;
            idx_q         <= '0;
            digit_out_q   <= '0;
            digit_valid_q <= 1'b0;
            seg_q         <= SEG_BLANK;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            seq_q         <= seq_d;
            idx_q         <= idx_d;
            digit_out_q   <= digit_out_d;
            digit_valid_q <= digit_valid_d;
            seg_q         <= seg_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign digit_out   = digit_out_q;
    assign digit_idx   = idx_q;
    assign digit_valid = digit_valid_q;
    assign seg         = seg_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
